name_lookup_sequencer: RTL

- Upstream control stage for a single trie level stage.
- Buffers one incoming name of up to MAX_NAME_LENGTH 32-bit words.
- Walks the level's binary search structure one word at a time by driving the level's address and lookup word, then reading back its next-pointer, match and no-child outputs.
- Reports the longest matched prefix length and the pointer reached; one lookup in flight at a time.

---
 rtl/name_lookup_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/name_lookup_sequencer.sv
// Control stage that buffers one name and walks a single trie level's search structure word by word.
// Optional step limit (abort on cyclic pointer structures) enabled by defining NAME_LOOKUP_STEP_LIMIT_EN.
module name_lookup_sequencer #(
    parameter int WORD_SIZE       = 32,
    parameter int PTR_W           = 4,
    parameter int MAX_NAME_LENGTH = 8,
    parameter int ROOT_ADDR       = 0,
    parameter int MAX_STEPS       = 64
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic [WORD_SIZE-1:0]               name_word_in,
    input  logic                               name_valid_in,
    input  logic                               name_last_in,
    output logic                               name_ready_out,
    output logic [PTR_W-1:0]                   lvl_address_out,
    output logic [WORD_SIZE-1:0]               lvl_lookup_cont_out,
    input  logic [PTR_W-1:0]                   lvl_next_pointer_in,
    input  logic                               lvl_is_match_in,
    input  logic                               lvl_no_child_in,
    output logic                               result_valid_out,
    input  logic                               result_ready_in,
    output logic [$clog2(MAX_NAME_LENGTH+1)-1:0] result_match_len_out,
    output logic [PTR_W-1:0]                   result_pointer_out,
    output logic                               result_full_match_out,
    output logic                               result_truncated_out,
    output logic                               result_timeout_out,
    output logic                               busy_out,
    output logic [2:0]                         state_dbg_out
);

    localparam int CW = $clog2(MAX_NAME_LENGTH + 1);
    localparam int IW = (MAX_NAME_LENGTH > 1) ? $clog2(MAX_NAME_LENGTH) : 1;
    localparam logic [PTR_W-1:0] ROOT = PTR_W'(ROOT_ADDR);
    localparam logic [CW-1:0]    MAX_CNT = CW'(MAX_NAME_LENGTH);

    // Both handshakes: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [WORD_SIZE-1:0] name_buf [MAX_NAME_LENGTH];
    logic [CW-1:0]        count_q;
    logic [IW-1:0]        idx_q;
    logic [PTR_W-1:0]     addr_q;
    logic [WORD_SIZE-1:0] word_q;
    logic [CW-1:0]        match_len_q;
    logic [PTR_W-1:0]     ptr_q;
    logic                 full_q;
    logic                 trunc_q;

    logic          name_xfer;
    logic [CW-1:0] idx_plus1;
    logic          last_word;
    logic          probe_again;
    logic          step_expired;

`ifdef NAME_LOOKUP_STEP_LIMIT_EN
    localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(MAX_STEPS - 1);
    logic [SW-1:0] steps_q;
    logic          timeout_q;
    logic          timed_out;
    assign step_expired = (steps_q == STEP_LAST);
`else
    assign step_expired = 1'b0;
`endif

    assign name_ready_out = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign name_xfer      = name_valid_in && name_ready_out;
    assign idx_plus1      = CW'(idx_q) + CW'(1);
    assign last_word      = (idx_plus1 == count_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        probe_again = 1'b0;
`ifdef NAME_LOOKUP_STEP_LIMIT_EN
        timed_out   = 1'b0;
`endif
        case (state_q)
            S_IDLE:  if (name_xfer) state_d = name_last_in ? S_ISSUE : S_LOAD;
            S_LOAD:  if (name_xfer && name_last_in) state_d = S_ISSUE;
            S_ISSUE: state_d = S_EVAL;
            S_EVAL: begin
                if ((lvl_is_match_in && last_word) || (!lvl_is_match_in && lvl_no_child_in)) begin
                    state_d = S_DONE;
                end else if (step_expired) begin
                    state_d = S_DONE;
`ifdef NAME_LOOKUP_STEP_LIMIT_EN
                    timed_out = 1'b1;
`endif
                end else begin
                    state_d     = S_ISSUE;
                    probe_again = 1'b1;
                end
            end
            S_DONE:  if (result_ready_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < MAX_NAME_LENGTH; i++) name_buf[i] <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            addr_q      <= ROOT;
            word_q      <= '0;
            match_len_q <= '0;
            ptr_q       <= '0;
            full_q      <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (name_xfer) begin
                        name_buf[0] <= name_word_in;
                        count_q     <= CW'(1);
                        if (name_last_in) begin
                            idx_q  <= '0;
                            addr_q <= ROOT;
                            word_q <= name_word_in;
                            ptr_q  <= ROOT;
                        end
                    end
                end
                S_LOAD: begin
                    if (name_xfer) begin
                        // Words beyond the buffer are swallowed so the producer never stalls.
                        if (count_q < MAX_CNT) begin
                            name_buf[count_q[IW-1:0]] <= name_word_in;
                            count_q <= count_q + CW'(1);
                        end else begin
                            trunc_q <= 1'b1;
                        end
                        if (name_last_in) begin
                            idx_q  <= '0;
                            addr_q <= ROOT;
                            word_q <= name_buf[0];
                            ptr_q  <= ROOT;
                        end
                    end
                end
                S_EVAL: begin
                    if (lvl_is_match_in) begin
                        match_len_q <= idx_plus1;
                        ptr_q       <= lvl_next_pointer_in;
                        if (last_word) full_q <= 1'b1;
                    end
                    if (probe_again) begin
                        addr_q <= lvl_next_pointer_in;
                        if (lvl_is_match_in) begin
                            idx_q  <= idx_q + IW'(1);
                            word_q <= name_buf[idx_q + IW'(1)];
                        end
                    end
                end
                S_DONE: begin
                    if (result_ready_in) begin
                        for (int i = 0; i < MAX_NAME_LENGTH; i++) name_buf[i] <= '0;
                        count_q     <= '0;
                        idx_q       <= '0;
                        addr_q      <= ROOT;
                        word_q      <= '0;
                        match_len_q <= '0;
                        ptr_q       <= '0;
                        full_q      <= 1'b0;
                        trunc_q     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NAME_LOOKUP_STEP_LIMIT_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            steps_q   <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == S_EVAL) begin
            steps_q <= steps_q + SW'(1);
            if (timed_out) timeout_q <= 1'b1;
        end else if (state_q == S_DONE && result_ready_in) begin
            steps_q   <= '0;
            timeout_q <= 1'b0;
        end
    end
    assign result_timeout_out = timeout_q;
`else
    assign result_timeout_out = 1'b0;
`endif

    assign lvl_address_out       = addr_q;
    assign lvl_lookup_cont_out   = word_q;
    assign result_valid_out      = (state_q == S_DONE);
    assign result_match_len_out  = match_len_q;
    assign result_pointer_out    = ptr_q;
    assign result_full_match_out = full_q;
    assign result_truncated_out  = trunc_q;
    assign busy_out              = (state_q != S_IDLE);
    assign state_dbg_out         = state_q;

endmodule
